// File: rtl/mux_pkg.sv
// -----------------------------------------------------------------------------
// mux_pkg
//   Shared constants and helpers for the N_CH:1 stream multiplexer.
//   MODE_SEL : channel chosen by the external select input
//   MODE_RR  : channel chosen by round-robin arbitration over valid inputs
//   clog2()  : ceiling log2, usable in parameter expressions
// -----------------------------------------------------------------------------
package mux_pkg;

    localparam int MODE_SEL = 0;
    localparam int MODE_RR  = 1;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/mux_n_1.sv
// -----------------------------------------------------------------------------
// mux_n_1
//   Combinational N_CH:1 multiplexer for WIDTH-bit words, built as a binary
//   tree of 2:1 stages (SEL_W levels). Level 1 is steered by the select LSB,
//   the last level by the select MSB.
// Ports
//   data_i  N_CH*WIDTH  channel i at [i*WIDTH +: WIDTH]
//   sel_i   SEL_W       channel index
//   data_o  WIDTH       selected word
// -----------------------------------------------------------------------------
module mux_n_1
    import mux_pkg::*;
#(
    parameter  int N_CH  = 4,
    parameter  int WIDTH = 8,
    localparam int SEL_W = clog2(N_CH)
) (
    input  logic [N_CH*WIDTH-1:0] data_i,
    input  logic [SEL_W-1:0]      sel_i,
    output logic [WIDTH-1:0]      data_o
);

    // Level l holds N_CH>>l candidates; level 0 is the raw channel words.
    for (genvar l = 0; l <= SEL_W; l++) begin : g_lvl
        logic [(N_CH>>l)-1:0][WIDTH-1:0] v;
        for (genvar j = 0; j < (N_CH >> l); j++) begin : g_el
            if (l == 0) begin : g_leaf
                assign v[j] = data_i[j*WIDTH +: WIDTH];
            end else begin : g_node
                assign v[j] = sel_i[l-1] ? g_lvl[l-1].v[2*j+1] : g_lvl[l-1].v[2*j];
            end
        end
    end

    assign data_o = g_lvl[SEL_W].v[0];

endmodule

// File: rtl/mux_n_1_stream.sv
// -----------------------------------------------------------------------------
// mux_n_1_stream
//   N_CH:1 registered stream multiplexer with valid/ready handshake on every
//   input channel and on the single output. One output register stage; full
//   throughput when out_ready stays high.
//   MODE_SEL : grant = sel, sampled each cycle
//   MODE_RR  : grant = first valid channel scanning from rr_ptr upwards (mod N_CH)
// Ports
//   clk, rst_n    clock, asynchronous active-low reset
//   in_data       N_CH*WIDTH  channel i at [i*WIDTH +: WIDTH]
//   in_valid      N_CH        per-channel valid
//   in_ready      N_CH        per-channel ready (combinational, only granted bit)
//   sel           SEL_W       channel select (MODE_SEL only)
//   out_data      WIDTH       registered data
//   out_valid     1           registered valid
//   out_ready     1           consumer ready
//   out_ch        SEL_W       channel that produced out_data
// -----------------------------------------------------------------------------
module mux_n_1_stream
    import mux_pkg::*;
#(
    parameter  int N_CH  = 4,
    parameter  int WIDTH = 8,
    parameter  int MODE  = MODE_SEL,
    localparam int SEL_W = clog2(N_CH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_CH*WIDTH-1:0] in_data,
    input  logic [N_CH-1:0]       in_valid,
    output logic [N_CH-1:0]       in_ready,
    input  logic [SEL_W-1:0]      sel,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [SEL_W-1:0]      out_ch
);

    logic                 out_valid_q, out_valid_d;
    logic [WIDTH-1:0]     out_data_q,  out_data_d;
    logic [SEL_W-1:0]     out_ch_q,    out_ch_d;
    logic [SEL_W-1:0]     rr_ptr_q,    rr_ptr_d;

    logic                 load_en;
    logic                 rr_found;
    logic [SEL_W-1:0]     rr_ch;
    logic [SEL_W-1:0]     gnt_ch;
    logic                 gnt_vld;
    logic                 xfer;
    logic [WIDTH-1:0]     mux_data;

    // The register can accept a new word when empty or when its word leaves now.
    assign load_en = !out_valid_q || out_ready;

    // Rotating priority scan; the index wraps naturally because N_CH is 2**SEL_W.
    always_comb begin
        logic [SEL_W-1:0] idx;
        rr_found = 1'b0;
        rr_ch    = rr_ptr_q;
        idx      = '0;
        for (int j = 0; j < N_CH; j++) begin
            idx = rr_ptr_q + SEL_W'(j);
            if (!rr_found && in_valid[idx]) begin
                rr_found = 1'b1;
                rr_ch    = idx;
            end
        end
    end

    always_comb begin
        if (MODE == MODE_RR) begin
            gnt_ch  = rr_ch;
            gnt_vld = rr_found;
        end else begin
            gnt_ch  = sel;
            gnt_vld = in_valid[sel];
        end
    end

    // In select mode ready follows sel alone so producers may wait on ready
    // before raising valid.
    always_comb begin
        in_ready = '0;
        if (load_en && (MODE == MODE_SEL || rr_found)) begin
            in_ready[gnt_ch] = 1'b1;
        end
    end

    assign xfer = load_en && gnt_vld;

    mux_n_1 #(
        .N_CH  (N_CH),
        .WIDTH (WIDTH)
    ) u_mux (
        .data_i (in_data),
        .sel_i  (gnt_ch),
        .data_o (mux_data)
    );

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        rr_ptr_d    = rr_ptr_q;
        if (load_en) begin
            out_valid_d = xfer;
        end
        if (xfer) begin
            out_data_d = mux_data;
            out_ch_d   = gnt_ch;
            if (MODE == MODE_RR) begin
                rr_ptr_d = gnt_ch + 1'b1;
            end
        end
    end

    // ---- output register stage ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            rr_ptr_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_mux_n_1_stream.sv
module tb_mux_n_1_stream;

    localparam int NCYC = 4000;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Two 4-channel 8-bit instances: index 0 = select mode, 1 = round-robin
    logic [1:0][31:0] a_data;
    logic [1:0][3:0]  a_vld, a_rdy;
    logic [1:0][1:0]  a_sel, a_och;
    logic [1:0][7:0]  a_od;
    logic [1:0]       a_ov, a_ordy;

    // Two 8-channel 16-bit instances for the random scoreboard run
    logic [1:0][127:0] b_data;
    logic [1:0][7:0]   b_vld, b_rdy;
    logic [1:0][2:0]   b_sel, b_och;
    logic [1:0][15:0]  b_od;
    logic [1:0]        b_ov, b_ordy;

    for (genvar m = 0; m < 2; m++) begin : g_dut
        mux_n_1_stream #(.N_CH(4), .WIDTH(8), .MODE(m)) u_a (
            .clk(clk), .rst_n(rst_n),
            .in_data(a_data[m]), .in_valid(a_vld[m]), .in_ready(a_rdy[m]),
            .sel(a_sel[m]),
            .out_data(a_od[m]), .out_valid(a_ov[m]), .out_ready(a_ordy[m]),
            .out_ch(a_och[m])
        );
        mux_n_1_stream #(.N_CH(8), .WIDTH(16), .MODE(m)) u_b (
            .clk(clk), .rst_n(rst_n),
            .in_data(b_data[m]), .in_valid(b_vld[m]), .in_ready(b_rdy[m]),
            .sel(b_sel[m]),
            .out_data(b_od[m]), .out_valid(b_ov[m]), .out_ready(b_ordy[m]),
            .out_ch(b_och[m])
        );
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        int         m;
        logic [1:0] sel;
        logic [3:0] vld;
        logic [31:0] data;
        logic       ordy;
        logic [3:0] ir;
        logic       ov;
        logic [7:0] od;
        logic [1:0] ch;
    } vec_t;

    function automatic vec_t mk(int m, logic [1:0] sel, logic [3:0] vld, logic [31:0] data,
                                logic ordy, logic [3:0] ir, logic ov, logic [7:0] od,
                                logic [1:0] ch);
        vec_t v;
        v.m = m; v.sel = sel; v.vld = vld; v.data = data; v.ordy = ordy;
        v.ir = ir; v.ov = ov; v.od = od; v.ch = ch;
        return v;
    endfunction

    typedef struct packed {
        logic [2:0]  ch;
        logic [15:0] d;
    } beat_t;

    beat_t q0[$];
    beat_t q1[$];

    vec_t        tbl[$];
    logic [31:0] d1, d2;
    logic [1:0]  stall_prev;
    logic [1:0][15:0] hold_d;
    logic [1:0][2:0]  hold_c;
    logic [2:0]  mptr;
    logic [2:0]  idx;
    logic [7:0]  exp_ir;
    logic        le, found;
    beat_t       nb, eb;
    int          qs;

    initial begin
        d1 = 32'h3CA52211;   // ch3..ch0 = 3C A5 22 11
        d2 = 32'hFFEEDDCC;   // ch3..ch0 = FF EE DD CC

        // Select mode: grant, invalid select, 3-cycle stall, release
        tbl.push_back(mk(0, 2'd2, 4'b1111, d1, 1'b1, 4'b0100, 1'b1, 8'hA5, 2'd2));
        tbl.push_back(mk(0, 2'd0, 4'b1111, d1, 1'b1, 4'b0001, 1'b1, 8'h11, 2'd0));
        tbl.push_back(mk(0, 2'd3, 4'b0111, d1, 1'b1, 4'b1000, 1'b0, 8'h11, 2'd0));
        tbl.push_back(mk(0, 2'd1, 4'b0010, d1, 1'b0, 4'b0010, 1'b1, 8'h22, 2'd1));
        tbl.push_back(mk(0, 2'd3, 4'b1111, d2, 1'b0, 4'b0000, 1'b1, 8'h22, 2'd1));
        tbl.push_back(mk(0, 2'd0, 4'b1111, d2, 1'b0, 4'b0000, 1'b1, 8'h22, 2'd1));
        tbl.push_back(mk(0, 2'd2, 4'b1111, d2, 1'b0, 4'b0000, 1'b1, 8'h22, 2'd1));
        tbl.push_back(mk(0, 2'd3, 4'b1111, d1, 1'b1, 4'b1000, 1'b1, 8'h3C, 2'd3));
        tbl.push_back(mk(0, 2'd3, 4'b0000, d1, 1'b1, 4'b1000, 1'b0, 8'h3C, 2'd3));
        tbl.push_back(mk(0, 2'd1, 4'b1111, d1, 1'b0, 4'b0010, 1'b1, 8'h22, 2'd1));
        // Round-robin: all valid with wrap, sparse ch1/ch3, idle, stall
        tbl.push_back(mk(1, 2'd3, 4'b1111, d1, 1'b1, 4'b0001, 1'b1, 8'h11, 2'd0));
        tbl.push_back(mk(1, 2'd0, 4'b1111, d1, 1'b1, 4'b0010, 1'b1, 8'h22, 2'd1));
        tbl.push_back(mk(1, 2'd0, 4'b1111, d1, 1'b1, 4'b0100, 1'b1, 8'hA5, 2'd2));
        tbl.push_back(mk(1, 2'd0, 4'b1111, d1, 1'b1, 4'b1000, 1'b1, 8'h3C, 2'd3));
        tbl.push_back(mk(1, 2'd2, 4'b1111, d1, 1'b1, 4'b0001, 1'b1, 8'h11, 2'd0));
        tbl.push_back(mk(1, 2'd2, 4'b1111, d1, 1'b1, 4'b0010, 1'b1, 8'h22, 2'd1));
        tbl.push_back(mk(1, 2'd0, 4'b1010, d1, 1'b1, 4'b1000, 1'b1, 8'h3C, 2'd3));
        tbl.push_back(mk(1, 2'd0, 4'b1010, d1, 1'b1, 4'b0010, 1'b1, 8'h22, 2'd1));
        tbl.push_back(mk(1, 2'd0, 4'b1010, d1, 1'b1, 4'b1000, 1'b1, 8'h3C, 2'd3));
        tbl.push_back(mk(1, 2'd1, 4'b0000, d1, 1'b1, 4'b0000, 1'b0, 8'h3C, 2'd3));
        tbl.push_back(mk(1, 2'd1, 4'b0100, d2, 1'b0, 4'b0100, 1'b1, 8'hEE, 2'd2));
        tbl.push_back(mk(1, 2'd0, 4'b1111, d1, 1'b0, 4'b0000, 1'b1, 8'hEE, 2'd2));
        tbl.push_back(mk(1, 2'd0, 4'b1111, d1, 1'b1, 4'b1000, 1'b1, 8'h3C, 2'd3));
        tbl.push_back(mk(1, 2'd0, 4'b0010, d1, 1'b1, 4'b0010, 1'b1, 8'h22, 2'd1));

        a_data = '0; a_vld = '0; a_sel = '0; a_ordy = '0;
        b_data = '0; b_vld = '0; b_sel = '0; b_ordy = '0;

        // Power-on reset, checked before any clock edge
        #1 rst_n = 1'b0;
        #1;
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("por_ov%0d", m), a_ov[m], 1'b0);
            chk($sformatf("por_od%0d", m), a_od[m], 8'h00);
            chk($sformatf("por_ch%0d", m), a_och[m], 2'd0);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven directed vectors
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            a_sel[tbl[i].m]  = tbl[i].sel;
            a_vld[tbl[i].m]  = tbl[i].vld;
            a_data[tbl[i].m] = tbl[i].data;
            a_ordy[tbl[i].m] = tbl[i].ordy;
            #1;
            chk($sformatf("row%0d_in_ready", i), a_rdy[tbl[i].m], tbl[i].ir);
            @(posedge clk);
            #1;
            chk($sformatf("row%0d_out_valid", i), a_ov[tbl[i].m], tbl[i].ov);
            chk($sformatf("row%0d_out_data", i), a_od[tbl[i].m], tbl[i].od);
            chk($sformatf("row%0d_out_ch", i), a_och[tbl[i].m], tbl[i].ch);
        end

        // Reset in the middle of a stall on both instances
        @(negedge clk);
        a_ordy = '0;
        a_vld  = {4'b1111, 4'b1111};
        @(posedge clk);
        #1;
        chk("stall_pre_ov", a_ov, 2'b11);
        chk("stall_pre_ch1", a_och[1], 2'd1);
        #2 rst_n = 1'b0;
        #1;
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("mid_rst_ov%0d", m), a_ov[m], 1'b0);
            chk($sformatf("mid_rst_od%0d", m), a_od[m], 8'h00);
            chk($sformatf("mid_rst_ch%0d", m), a_och[m], 2'd0);
        end
        @(negedge clk);
        rst_n  = 1'b1;
        a_ordy = 2'b11;
        #1;
        chk("post_rst_rr_ready", a_rdy[1], 4'b0001);
        @(posedge clk);
        #1;
        chk("post_rst_rr_ch", a_och[1], 2'd0);
        chk("post_rst_rr_data", a_od[1], 8'h11);
        @(negedge clk);
        a_vld = '0;

        // Random traffic on the 8-channel instances, both modes, scoreboard checked
        stall_prev = '0;
        hold_d = '0;
        hold_c = '0;
        mptr = '0;
        for (int cyc = 0; cyc < NCYC + 20; cyc++) begin
            @(negedge clk);
            for (int m = 0; m < 2; m++) begin
                if (cyc < NCYC) begin
                    b_vld[m]  = 8'($urandom);
                    b_ordy[m] = ($urandom_range(0, 3) != 0);
                    b_sel[m]  = 3'($urandom);
                    for (int k = 0; k < 4; k++) b_data[m][k*32 +: 32] = $urandom;
                end else begin
                    b_vld[m]  = '0;
                    b_ordy[m] = 1'b1;
                end
            end
            #1;
            for (int m = 0; m < 2; m++) begin
                if (stall_prev[m]) begin
                    chk($sformatf("rnd%0d_hold c%0d", m, cyc), {b_ov[m], b_och[m], b_od[m]},
                        {1'b1, hold_c[m], hold_d[m]});
                end
                stall_prev[m] = b_ov[m] && !b_ordy[m];
                hold_d[m] = b_od[m];
                hold_c[m] = b_och[m];

                le = !b_ov[m] || b_ordy[m];
                exp_ir = '0;
                if (le) begin
                    if (m == 0) begin
                        exp_ir[b_sel[m]] = 1'b1;
                    end else begin
                        found = 1'b0;
                        for (int j = 0; j < 8; j++) begin
                            idx = mptr + 3'(j);
                            if (!found && b_vld[1][idx]) begin
                                found = 1'b1;
                                exp_ir[idx] = 1'b1;
                            end
                        end
                    end
                end
                chk($sformatf("rnd%0d_in_ready c%0d", m, cyc), b_rdy[m], exp_ir);

                if (b_ov[m] && b_ordy[m]) begin
                    eb = '0;
                    if (m == 0) begin
                        qs = q0.size();
                        if (qs > 0) eb = q0.pop_front();
                    end else begin
                        qs = q1.size();
                        if (qs > 0) eb = q1.pop_front();
                    end
                    if (qs == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL rnd%0d_extra_beat c%0d: got ch %0d data %0h expected no beat",
                                 m, cyc, b_och[m], b_od[m]);
                    end else begin
                        chk($sformatf("rnd%0d_beat c%0d", m, cyc), {b_och[m], b_od[m]}, eb);
                    end
                end

                for (int c = 0; c < 8; c++) begin
                    if (b_vld[m][c] && b_rdy[m][c]) begin
                        nb.ch = 3'(c);
                        nb.d  = b_data[m][c*16 +: 16];
                        if (m == 0) q0.push_back(nb);
                        else begin
                            q1.push_back(nb);
                            mptr = 3'(c) + 3'd1;
                        end
                    end
                end
            end
        end
        chk("rnd0_drained", q0.size(), 0);
        chk("rnd1_drained", q1.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
